mtip_frame_arb: RTL and testbench
=================================

Name: mtip_frame_arb

Overview:
- Frame-granular arbiter that shares one frame-extractor input between two MTIP RX channels.
- Each channel is a show-ahead, FIFO-buffered frame stream. The block round-robins between channels only on frame boundaries and inserts a minimum inter-packet gap after every frame.
- It enforces a maximum frame length and closes malformed frames (missing EOP, orphan words) so the extractor only ever sees well-formed SOP..EOP sequences, tagged with the source channel.

Parameters:
- IPG_CNT, 2, idle cycles forced on the output after each EOP; legal range 2..15.
- MAX_WORDS, 537, maximum 32-bit words per frame, SOP and EOP words inclusive.
- CNT_W, 16, width of the saturating status counters.

Ports:
- iCLK  in  1  212.5 MHz clock
- iRESET_n  in  1  reset; asynchronous, active-low
- iCH_EN  in  2  per-channel enable (configuration, quasi-static)
- iCH0_DATA  in  32  channel 0 head-of-queue data
- iCH0_SOP / iCH0_EOP / iCH0_ERR  in  1 each  channel 0 head flags
- iCH0_VAL  in  1  channel 0 head word valid
- oCH0_RD  out  1  channel 0 consume strobe
- iCH1_DATA, iCH1_SOP, iCH1_EOP, iCH1_ERR, iCH1_VAL, oCH1_RD  same as channel 0
- oDATA  out  32  output data; zero when oDVAL=0
- oSOP / oEOP / oERR  out  1 each  output flags, qualified by oDVAL
- oDVAL  out  1  output word valid
- oCH  out  1  source channel of the current output word
- oBUSY  out  1  FSM not in IDLE
- oTRUNC_CNT  out  CNT_W  frames truncated or aborted
- oORPHAN_CNT  out  CNT_W  words discarded outside any frame

Behaviour:
- Handshake:
  - A head word is consumed when iCHn_VAL && oCHn_RD in the same cycle.
  - oCHn_RD is combinational from FSM state and iCHn_VAL, and is never asserted when iCHn_VAL=0.
  - The head word holds until it is consumed.
- Latency: every output signal is registered; a consumed word appears on the output exactly 1 cycle after its oCHn_RD.
- Reset: all outputs are 0, the FSM is in IDLE, the round-robin pointer selects ch0 first, and both counters are 0.
- Reset mid-frame abandons the frame; no closing word is emitted.
- State IDLE:
  - A channel is eligible when iCH_EN[n] && iCHn_VAL && iCHn_SOP.
  - If both channels are eligible, grant the channel that was not granted last.
  - On grant: consume the SOP word, load the word counter to 1, go to XFER.
  - An enabled channel whose head is valid but not SOP gets RD=1 and the word is discarded; oORPHAN_CNT increments by 1, or by 2 if both channels discard in the same cycle. Discards on both channels proceed in parallel with a grant to the other channel.
  - A disabled channel's head is left untouched.
- State XFER (granted channel g):
  - RD_g = VAL_g; the other channel's RD is 0.
  - Each consumed word increments the word counter.
  - Consumed word with EOP=1: forward it and go to GAP.
  - Consumed word that reaches MAX_WORDS without EOP: forward it with EOP=1 and ERR=1, increment oTRUNC_CNT, go to DRAIN.
  - Head has SOP=1 (new frame before EOP):
    - Do not consume it.
    - Emit one abort word: DATA=0, EOP=1, ERR=1, DVAL=1, CH=g.
    - Increment oTRUNC_CNT and go to GAP.
  - Simultaneous SOP and EOP on one word mid-frame is treated as the SOP case.
  - iCH_EN dropping mid-frame has no effect; the frame completes.
- State DRAIN: RD_g = VAL_g and words are discarded (not counted as orphans) until a word with EOP is consumed, then go to GAP. A head with SOP=1 ends DRAIN without being consumed, then go to GAP.
- State GAP:
  - The gap counter is loaded to IPG_CNT on entry.
  - No RD on either channel; oDVAL=0.
  - Decrement each cycle; go to IDLE when the counter reaches 0.
  - This guarantees at least IPG_CNT idle cycles between the EOP word and the next SOP word.
- Status counters saturate at all-ones; they never wrap.
- oERR on a forwarded word equals the input ERR, except that it is forced to 1 on truncation and abort words.

Decomposition:
- Shared package mtip_pkg: FSM state encoding (IDLE, XFER, DRAIN, GAP, one-hot), the default IPG_CNT, MAX_WORDS for FC max frame, and a typedef for the 36-bit {ERR,EOP,SOP,DATA} word.
- One sub-module: mtip_sat_cntr, a CNT_W-bit saturating counter with a 0/1/2 increment input, instantiated twice.

Test Plan:
- 3-word frame on ch0 only (SOP, -, EOP), ch1 idle -> output words on cycles t+1..t+3 with CH=0, then ≥2 idle cycles; counters stay 0.
- Both channels hold 4-word frames continuously -> grant order ch0, ch1, ch0, ch1; exactly 2 idle cycles between each EOP and the next SOP.
- ch0 frame of 600 words, no EOP until word 600 -> word 537 is output with EOP=1 ERR=1, words 538..600 are dropped, oTRUNC_CNT=1, then ch1 frame is granted.
- ch1 head words without SOP (3 words) while IDLE -> all 3 consumed, no output, oORPHAN_CNT=3.
- ch0 SOP, 2 data words, then a new SOP -> abort word (DATA=0, EOP=1, ERR=1) is output; new frame starts after gap, SOP preserved; oTRUNC_CNT=1.
- iCH_EN=2'b01 with both channels holding frames -> only ch0 granted, ch1 RD stays 0; assert reset mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/mtip_pkg.sv
// Shared types and defaults for the MTIP RX frame arbiter.
// Includes the FSM encoding, the frame word layout and the counter increment helper.
package mtip_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_XFER  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_GAP   = 4'b1000
  } state_t;

  localparam int IPG_CNT_DEF  = 2;
  localparam int MAX_WORDS_FC = 537;

  typedef struct packed {
    logic        err;
    logic        eop;
    logic        sop;
    logic [31:0] data;
  } word_t;

  // Number of asserted events among two, as a 0/1/2 increment.
  function automatic logic [1:0] sum2(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/mtip_sat_cntr.sv
// Saturating status counter.
// Each cycle it adds 0, 1 or 2 and holds at all-ones instead of wrapping.
module mtip_sat_cntr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W:0]   sum_s;

  // Widened sum so the carry-out flags saturation.
  always_comb begin
    sum_s = {1'b0, cnt_r} + {{(CNT_W-1){1'b0}}, inc};
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (sum_s[CNT_W]) begin
      cnt_r <= '1;
    end else begin
      cnt_r <= sum_s[CNT_W-1:0];
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/mtip_frame_arb.sv
// Frame-granular round-robin arbiter between two MTIP RX channels.
// It enforces the inter-packet gap and maximum length, and closes malformed frames.
module mtip_frame_arb
  import mtip_pkg::*;
#(
  parameter int IPG_CNT   = IPG_CNT_DEF,
  parameter int MAX_WORDS = MAX_WORDS_FC,
  parameter int CNT_W     = 16
) (
  input  logic             iCLK,
  input  logic             iRESET_n,
  input  logic [1:0]       iCH_EN,
  input  logic [31:0]      iCH0_DATA,
  input  logic             iCH0_SOP,
  input  logic             iCH0_EOP,
  input  logic             iCH0_ERR,
  input  logic             iCH0_VAL,
  output logic             oCH0_RD,
  input  logic [31:0]      iCH1_DATA,
  input  logic             iCH1_SOP,
  input  logic             iCH1_EOP,
  input  logic             iCH1_ERR,
  input  logic             iCH1_VAL,
  output logic             oCH1_RD,
  output logic [31:0]      oDATA,
  output logic             oSOP,
  output logic             oEOP,
  output logic             oERR,
  output logic             oDVAL,
  output logic             oCH,
  output logic             oBUSY,
  output logic [CNT_W-1:0] oTRUNC_CNT,
  output logic [CNT_W-1:0] oORPHAN_CNT
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);

  state_t          state_r;
  logic            grant_r;
  logic            last_r;
  logic [WC_W-1:0] wcnt_r;
  logic [3:0]      gap_r;
  word_t           out_r;
  logic            dval_r;
  logic            ch_r;

  word_t           head0_s, head1_s, head_g_s;
  logic            elig0_s, elig1_s, orph0_s, orph1_s;
  logic            pick_s, take_s, val_g_s;
  logic            abort_s, fwd_s, cap_s;
  logic [WC_W-1:0] wnext_s;
  logic            rd0_s, rd1_s;
  logic [1:0]      orph_inc_s, trunc_inc_s;

  // Head decode, eligibility and round-robin pick.
  always_comb begin
    head0_s = '{err: iCH0_ERR, eop: iCH0_EOP, sop: iCH0_SOP, data: iCH0_DATA};
    head1_s = '{err: iCH1_ERR, eop: iCH1_EOP, sop: iCH1_SOP, data: iCH1_DATA};
    elig0_s = iCH_EN[0] & iCH0_VAL & iCH0_SOP;
    elig1_s = iCH_EN[1] & iCH1_VAL & iCH1_SOP;
    orph0_s = iCH_EN[0] & iCH0_VAL & ~iCH0_SOP;
    orph1_s = iCH_EN[1] & iCH1_VAL & ~iCH1_SOP;
    if (elig0_s && elig1_s) begin
      pick_s = ~last_r;
    end else if (elig1_s) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    take_s   = elig0_s | elig1_s;
    head_g_s = grant_r ? head1_s : head0_s;
    val_g_s  = grant_r ? iCH1_VAL : iCH0_VAL;
    wnext_s  = wcnt_r + WC_W'(1);
    // A SOP head mid-frame is never consumed; it starts the next frame.
    abort_s  = val_g_s & head_g_s.sop;
    fwd_s    = val_g_s & ~head_g_s.sop;
    cap_s    = fwd_s & ~head_g_s.eop & (wnext_s == WC_W'(MAX_WORDS));
  end

  // Consume strobes and counter increments.
  always_comb begin
    rd0_s       = 1'b0;
    rd1_s       = 1'b0;
    orph_inc_s  = 2'b00;
    trunc_inc_s = 2'b00;
    case (state_r)
      ST_IDLE: begin
        rd0_s      = orph0_s | (take_s & ~pick_s);
        rd1_s      = orph1_s | (take_s & pick_s);
        orph_inc_s = sum2(orph0_s, orph1_s);
      end
      ST_XFER: begin
        rd0_s       = ~grant_r & fwd_s;
        rd1_s       = grant_r & fwd_s;
        trunc_inc_s = {1'b0, abort_s | cap_s};
      end
      ST_DRAIN: begin
        rd0_s = ~grant_r & fwd_s;
        rd1_s = grant_r & fwd_s;
      end
      default: begin
        rd0_s = 1'b0;
        rd1_s = 1'b0;
      end
    endcase
  end

  // Arbitration FSM with registered output word.
  always_ff @(posedge iCLK or negedge iRESET_n) begin
    if (!iRESET_n) begin
      state_r <= ST_IDLE;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
      wcnt_r  <= '0;
      gap_r   <= 4'd0;
      out_r   <= '0;
      dval_r  <= 1'b0;
      ch_r    <= 1'b0;
    end else begin
      out_r  <= '0;
      dval_r <= 1'b0;
      ch_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            out_r   <= pick_s ? head1_s : head0_s;
            dval_r  <= 1'b1;
            ch_r    <= pick_s;
            grant_r <= pick_s;
            last_r  <= pick_s;
            wcnt_r  <= WC_W'(1);
            // A single-word frame (SOP with EOP) is already closed.
            if (pick_s ? iCH1_EOP : iCH0_EOP) begin
              state_r <= ST_GAP;
              gap_r   <= 4'(IPG_CNT);
            end else begin
              state_r <= ST_XFER;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (abort_s) begin
            out_r   <= '{err: 1'b1, eop: 1'b1, sop: 1'b0, data: 32'h0000_0000};
            dval_r  <= 1'b1;
            ch_r    <= grant_r;
            state_r <= ST_GAP;
            gap_r   <= 4'(IPG_CNT);
          end else if (fwd_s) begin
            out_r   <= '{err: head_g_s.err | cap_s, eop: head_g_s.eop | cap_s,
                         sop: 1'b0, data: head_g_s.data};
            dval_r  <= 1'b1;
            ch_r    <= grant_r;
            wcnt_r  <= wnext_s;
            if (head_g_s.eop) begin
              state_r <= ST_GAP;
              gap_r   <= 4'(IPG_CNT);
            end else if (cap_s) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_XFER;
            end
          end else begin
            state_r <= ST_XFER;
          end
        end
        ST_DRAIN: begin
          if (val_g_s && (head_g_s.sop || head_g_s.eop)) begin
            state_r <= ST_GAP;
            gap_r   <= 4'(IPG_CNT);
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_GAP: begin
          gap_r <= gap_r - 4'd1;
          if (gap_r <= 4'd1) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_GAP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  mtip_sat_cntr #(.CNT_W(CNT_W)) u_trunc_cnt (
    .clk   (iCLK),
    .rst_n (iRESET_n),
    .inc   (trunc_inc_s),
    .cnt   (oTRUNC_CNT)
  );

  mtip_sat_cntr #(.CNT_W(CNT_W)) u_orphan_cnt (
    .clk   (iCLK),
    .rst_n (iRESET_n),
    .inc   (orph_inc_s),
    .cnt   (oORPHAN_CNT)
  );

  // Strobes are held low while reset is asserted.
  assign oCH0_RD = iRESET_n & rd0_s;
  assign oCH1_RD = iRESET_n & rd1_s;
  assign oDATA   = out_r.data;
  assign oSOP    = out_r.sop;
  assign oEOP    = out_r.eop;
  assign oERR    = out_r.err;
  assign oDVAL   = dval_r;
  assign oCH     = ch_r;
  assign oBUSY   = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mtip_frame_arb.sv
// Directed bench for mtip_frame_arb: single-cycle IDLE vectors plus
// multi-cycle frame scenarios driven from show-ahead queue models.
module tb_mtip_frame_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic [31:0] d0, d1;
  logic        s0, e0, r0, v0, s1, e1, r1, v1;
  logic        rd0, rd1;
  logic [31:0] odata;
  logic        osop, oeop, oerr, odval, och, obusy;
  logic [15:0] trunc_cnt, orph_cnt;

  always #5 clk = ~clk;

  mtip_frame_arb dut (
    .iCLK(clk), .iRESET_n(rst_n), .iCH_EN(en),
    .iCH0_DATA(d0), .iCH0_SOP(s0), .iCH0_EOP(e0), .iCH0_ERR(r0), .iCH0_VAL(v0), .oCH0_RD(rd0),
    .iCH1_DATA(d1), .iCH1_SOP(s1), .iCH1_EOP(e1), .iCH1_ERR(r1), .iCH1_VAL(v1), .oCH1_RD(rd1),
    .oDATA(odata), .oSOP(osop), .oEOP(oeop), .oERR(oerr), .oDVAL(odval), .oCH(och),
    .oBUSY(obusy), .oTRUNC_CNT(trunc_cnt), .oORPHAN_CNT(orph_cnt)
  );

  typedef struct {
    logic [1:0]  en;
    logic        v0, s0;
    logic [31:0] d0;
    logic        v1, s1;
    logic [31:0] d1;
    logic        erd0, erd1, edval, ech, esop;
    logic [31:0] edata;
    logic [15:0] eorph;
  } vec_t;

  vec_t        vt [7];
  logic [34:0] q0 [$];
  logic [34:0] q1 [$];
  logic [36:0] olog [$];
  logic [36:0] oexp [$];
  int          n_pass = 0;
  int          n_total = 0;
  int          rd1_seen;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic do_reset(input logic [1:0] en_v);
    rst_n = 1'b0;
    en = en_v;
    {d0, s0, e0, r0, v0} = '0;
    {d1, s1, e1, r1, v1} = '0;
    q0.delete(); q1.delete(); olog.delete(); oexp.delete();
    rd1_seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_heads();
    if (q0.size() > 0) begin {r0, e0, s0, d0} = q0[0]; v0 = 1'b1; end
    else begin {r0, e0, s0, d0} = '0; v0 = 1'b0; end
    if (q1.size() > 0) begin {r1, e1, s1, d1} = q1[0]; v1 = 1'b1; end
    else begin {r1, e1, s1, d1} = '0; v1 = 1'b0; end
  endtask

  task automatic run(input int n);
    logic a0, a1;
    for (int i = 0; i < n; i++) begin
      drive_heads();
      #1;
      a0 = rd0; a1 = rd1;
      if (a1) rd1_seen++;
      @(posedge clk);
      #1;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      olog.push_back({odval, och, oerr, oeop, osop, odata});
    end
  endtask

  // flags are {err,eop,sop}
  task automatic ew(input logic ch, input logic [2:0] f, input logic [31:0] d);
    oexp.push_back({1'b1, ch, f, d});
  endtask

  task automatic ei(input int n);
    for (int i = 0; i < n; i++) oexp.push_back(37'd0);
  endtask

  task automatic cmp_log(input string nm);
    chk({nm, "_len"}, 64'(olog.size()), 64'(oexp.size()));
    for (int i = 0; i < oexp.size() && i < olog.size(); i++)
      chk($sformatf("%s_c%0d", nm, i), 64'(olog[i]), 64'(oexp[i]));
  endtask

  initial begin
    // en, v0,s0,d0, v1,s1,d1, rd0,rd1, dval,ch,sop, data, orph
    vt[0] = '{2'b11, 1'b1, 1'b1, 32'hAAAA_0001, 1'b1, 1'b1, 32'hBBBB_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 16'd0};
    vt[1] = '{2'b11, 1'b1, 1'b0, 32'hAAAA_0002, 1'b1, 1'b1, 32'hBBBB_0002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBBBB_0002, 16'd1};
    vt[2] = '{2'b11, 1'b1, 1'b0, 32'hAAAA_0003, 1'b1, 1'b0, 32'hBBBB_0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 16'd2};
    vt[3] = '{2'b00, 1'b1, 1'b1, 32'hAAAA_0004, 1'b1, 1'b1, 32'hBBBB_0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 16'd0};
    vt[4] = '{2'b10, 1'b1, 1'b1, 32'hAAAA_0005, 1'b1, 1'b1, 32'hBBBB_0005, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBBBB_0005, 16'd0};
    vt[5] = '{2'b11, 1'b0, 1'b1, 32'hAAAA_0006, 1'b0, 1'b1, 32'hBBBB_0006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 16'd0};
    vt[6] = '{2'b01, 1'b1, 1'b0, 32'hAAAA_0007, 1'b1, 1'b0, 32'hBBBB_0007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 16'd1};

    // Reset state
    do_reset(2'b11);
    #1;
    chk("rst_dval", 64'(odval), 64'd0);
    chk("rst_busy", 64'(obusy), 64'd0);
    chk("rst_trunc", 64'(trunc_cnt), 64'd0);
    chk("rst_orph", 64'(orph_cnt), 64'd0);

    // Single-cycle IDLE decisions, each from a fresh reset
    for (int i = 0; i < 7; i++) begin
      do_reset(vt[i].en);
      v0 = vt[i].v0; s0 = vt[i].s0; d0 = vt[i].d0;
      v1 = vt[i].v1; s1 = vt[i].s1; d1 = vt[i].d1;
      #1;
      chk($sformatf("v%0d_rd0", i), 64'(rd0), 64'(vt[i].erd0));
      chk($sformatf("v%0d_rd1", i), 64'(rd1), 64'(vt[i].erd1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dval", i), 64'(odval), 64'(vt[i].edval));
      chk($sformatf("v%0d_ch", i), 64'(och), 64'(vt[i].ech));
      chk($sformatf("v%0d_sop", i), 64'(osop), 64'(vt[i].esop));
      chk($sformatf("v%0d_data", i), 64'(odata), 64'(vt[i].edata));
      chk($sformatf("v%0d_orph", i), 64'(orph_cnt), 64'(vt[i].eorph));
    end

    // 3-word frame on ch0
    do_reset(2'b11);
    q0.push_back({3'b001, 32'h0000_00A1});
    q0.push_back({3'b000, 32'h0000_00A2});
    q0.push_back({3'b010, 32'h0000_00A3});
    run(8);
    ew(1'b0, 3'b001, 32'h0000_00A1); ew(1'b0, 3'b000, 32'h0000_00A2); ew(1'b0, 3'b010, 32'h0000_00A3); ei(5);
    cmp_log("s1");
    chk("s1_trunc", 64'(trunc_cnt), 64'd0);
    chk("s1_orph", 64'(orph_cnt), 64'd0);

    // Round robin with 4-word frames on both channels
    do_reset(2'b11);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++) begin
        q0.push_back({1'b0, k == 3, k == 0, 8'hC0, 8'(f), 8'h00, 8'(k)});
        q1.push_back({1'b0, k == 3, k == 0, 8'hC1, 8'(f), 8'h00, 8'(k)});
      end
    run(26);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 4; k++)
          ew(1'(c), {1'b0, k == 3, k == 0}, {7'h60, 1'(c), 8'(f), 8'h00, 8'(k)});
        ei(2);
      end
    ei(2);
    cmp_log("s2");

    // 600-word frame on ch0 truncated at 537, then ch1 frame
    do_reset(2'b11);
    for (int k = 1; k <= 600; k++) q0.push_back({1'b0, k == 600, k == 1, 32'(k)});
    for (int k = 0; k < 4; k++) q1.push_back({1'b0, k == 3, k == 0, 32'hD000_0000 + 32'(k)});
    run(610);
    for (int k = 1; k <= 536; k++) ew(1'b0, {2'b00, k == 1}, 32'(k));
    ew(1'b0, 3'b110, 32'd537);
    ei(65);
    for (int k = 0; k < 4; k++) ew(1'b1, {1'b0, k == 3, k == 0}, 32'hD000_0000 + 32'(k));
    ei(4);
    cmp_log("s3");
    chk("s3_trunc", 64'(trunc_cnt), 64'd1);
    chk("s3_orph", 64'(orph_cnt), 64'd0);
    chk("s3_q0_left", 64'(q0.size()), 64'd0);

    // Orphan words on ch1
    do_reset(2'b11);
    for (int k = 1; k <= 3; k++) q1.push_back({3'b000, 32'hE000_0000 + 32'(k)});
    run(5);
    ei(5);
    cmp_log("s4");
    chk("s4_orph", 64'(orph_cnt), 64'd3);
    chk("s4_q1_left", 64'(q1.size()), 64'd0);

    // New SOP before EOP forces an abort word
    do_reset(2'b11);
    q0.push_back({3'b001, 32'h0000_00F1});
    q0.push_back({3'b000, 32'h0000_00F2});
    q0.push_back({3'b000, 32'h0000_00F3});
    q0.push_back({3'b001, 32'h0000_00F4});
    q0.push_back({3'b000, 32'h0000_00F5});
    q0.push_back({3'b010, 32'h0000_00F6});
    run(12);
    ew(1'b0, 3'b001, 32'h0000_00F1); ew(1'b0, 3'b000, 32'h0000_00F2); ew(1'b0, 3'b000, 32'h0000_00F3);
    ew(1'b0, 3'b110, 32'h0000_0000); ei(2);
    ew(1'b0, 3'b001, 32'h0000_00F4); ew(1'b0, 3'b000, 32'h0000_00F5); ew(1'b0, 3'b010, 32'h0000_00F6); ei(3);
    cmp_log("s5");
    chk("s5_trunc", 64'(trunc_cnt), 64'd1);
    chk("s5_orph", 64'(orph_cnt), 64'd0);

    // ch1 disabled, then reset in the middle of a ch0 frame
    do_reset(2'b01);
    for (int k = 0; k < 4; k++) begin
      q0.push_back({1'b0, k == 3, k == 0, 32'h7000_0000 + 32'(k)});
      q1.push_back({1'b0, k == 3, k == 0, 32'h7100_0000 + 32'(k)});
    end
    run(8);
    for (int k = 0; k < 6; k++) q0.push_back({1'b0, k == 5, k == 0, 32'h7200_0000 + 32'(k)});
    run(3);
    for (int k = 0; k < 4; k++) ew(1'b0, {1'b0, k == 3, k == 0}, 32'h7000_0000 + 32'(k));
    ei(4);
    for (int k = 0; k < 3; k++) ew(1'b0, {2'b00, k == 0}, 32'h7200_0000 + 32'(k));
    cmp_log("s6");
    chk("s6_rd1_seen", 64'(rd1_seen), 64'd0);
    chk("s6_q1_left", 64'(q1.size()), 64'd4);
    chk("s6_busy_pre", 64'(obusy), 64'd1);
    drive_heads();
    rst_n = 1'b0;
    #1;
    chk("s6_rst_outs", 64'({odval, osop, oeop, oerr, och, obusy, rd0, rd1}), 64'd0);
    chk("s6_rst_data", 64'(odata), 64'd0);
    chk("s6_rst_cnts", 64'({trunc_cnt, orph_cnt}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
